// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register slave.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int         CMD_W   = 8;
    localparam logic [7:0] ADDR_ID = 8'h00;

    // Address is out of range when it lies above the highest channel number.
    function automatic logic is_addr_err(input logic [7:0] addr, input logic [7:0] n_ch);
        return (addr > n_ch);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin plus rise/fall strobes.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the pin through the synchroniser and keep one extra delayed copy for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave: 8-bit channel address in, coherent DATA_W-bit snapshot out, all in i_clk domain.
module spi_reg_slave
    import spi_reg_pkg::*;
#(
    parameter int                N_CH        = 3,
    parameter int                DATA_W      = 40,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] ID_WORD     = DATA_W'(40'h00_0000_C0DE)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_CH*DATA_W-1:0]   i_ch_data,
    input  logic                     i_spi_sclk,
    input  logic                     i_spi_cs_n,
    input  logic                     i_spi_mosi,
    output logic                     o_spi_miso,
    output logic                     o_spi_miso_oe,
    output logic [CMD_W-1:0]         o_cmd,
    output logic                     o_cmd_valid,
    output logic                     o_err,
    output logic                     o_busy
);

    localparam int         CNT_W  = $clog2(DATA_W + 1);
    localparam logic [7:0] N_CH_B = 8'(N_CH);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_cs_level, w_cs_rise, w_cs_fall;
    logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

    state_e             r_state, w_state;
    logic [CMD_W-1:0]   r_cmd_sr, w_cmd_sr;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [DATA_W-1:0]  r_snap, w_snap;
    logic               r_miso, w_miso;
    logic [CMD_W-1:0]   r_cmd, w_cmd;
    logic               r_cmd_valid, w_cmd_valid;
    logic               r_err, w_err;
    logic               r_busy;
    logic [CMD_W-1:0]   w_cmd_byte;
    logic [DATA_W-1:0]  w_sel_word;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_spi_sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    // CS_n resets to the asserted level so a release during a live frame produces no fall strobe.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_spi_cs_n),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_spi_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
    );

    assign w_cmd_byte = {r_cmd_sr[CMD_W-2:0], w_mosi};

    // Address decode of the command byte being completed: ID, channel addr-1, or zero.
    always_comb begin
        w_sel_word = '0;
        if (w_cmd_byte == ADDR_ID) begin
            w_sel_word = ID_WORD;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (w_cmd_byte == 8'(k + 1)) begin
                    w_sel_word = i_ch_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Next-state and datapath: CS_n rise wins over everything, SCLK edges only act inside a frame.
    always_comb begin
        w_state     = r_state;
        w_cmd_sr    = r_cmd_sr;
        w_cnt       = r_cnt;
        w_snap      = r_snap;
        w_miso      = r_miso;
        w_cmd       = r_cmd;
        w_cmd_valid = 1'b0;
        w_err       = 1'b0;
        if (w_cs_rise) begin
            w_state = IDLE;
            w_miso  = 1'b0;
            w_cnt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_miso = 1'b0;
                    if (w_cs_fall) begin
                        w_state  = CMD;
                        w_cnt    = '0;
                        w_cmd_sr = '0;
                    end else begin
                        w_state = IDLE;
                    end
                end
                CMD: begin
                    if (w_sclk_rise) begin
                        w_cmd_sr = w_cmd_byte;
                        if (r_cnt == CNT_W'(CMD_W - 1)) begin
                            w_cnt       = '0;
                            w_cmd       = w_cmd_byte;
                            w_cmd_valid = 1'b1;
                            w_err       = is_addr_err(w_cmd_byte, N_CH_B);
                            w_snap      = w_sel_word;
                            w_state     = DATA;
                        end else begin
                            w_cnt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state = CMD;
                    end
                end
                DATA: begin
                    if (w_sclk_fall && (r_cnt != CNT_W'(DATA_W))) begin
                        w_miso = r_snap[DATA_W-1];
                        w_snap = {r_snap[DATA_W-2:0], 1'b0};
                        w_cnt  = r_cnt + CNT_W'(1);
                    end else if (w_sclk_rise && (r_cnt == CNT_W'(DATA_W))) begin
                        w_state = DONE;
                        w_miso  = 1'b0;
                    end else begin
                        w_state = DATA;
                    end
                end
                DONE: begin
                    w_miso = 1'b0;
                end
                default: begin
                    w_state = IDLE;
                    w_miso  = 1'b0;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Datapath and output registers; busy/OE follow the registered frame state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cmd_sr    <= '0;
            r_cnt       <= '0;
            r_snap      <= '0;
            r_miso      <= 1'b0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_cmd_sr    <= w_cmd_sr;
            r_cnt       <= w_cnt;
            r_snap      <= w_snap;
            r_miso      <= w_miso;
            r_cmd       <= w_cmd;
            r_cmd_valid <= w_cmd_valid;
            r_err       <= w_err;
            r_busy      <= (w_state != IDLE);
        end
    end

    assign o_spi_miso    = r_miso;
    assign o_spi_miso_oe = r_busy;
    assign o_busy        = r_busy;
    assign o_cmd         = r_cmd;
    assign o_cmd_valid   = r_cmd_valid;
    assign o_err         = r_err;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: SPI master model at i_clk/8, SYNC_STAGES=3.
module tb_spi_reg_slave;

    localparam int              N_CH   = 3;
    localparam int              DATA_W = 40;
    localparam logic [DATA_W-1:0] ID   = 40'h00_0000_C0DE;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   sclk = 1'b0;
    logic                   cs_n = 1'b1;
    logic                   mosi = 1'b0;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic                   miso, miso_oe, cmd_valid, err, busy;
    logic [7:0]             cmd_out;

    logic [DATA_W-1:0] ch_model [N_CH];
    int         checks = 0;
    int         failures = 0;
    int         n_valid = 0;
    int         n_err = 0;
    logic [7:0] last_cmd = 8'h00;
    bit         exp_q [$];

    spi_reg_slave #(
        .N_CH(N_CH), .DATA_W(DATA_W), .SYNC_STAGES(3), .ID_WORD(ID)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ch_data(ch_data),
        .i_spi_sclk(sclk), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi),
        .o_spi_miso(miso), .o_spi_miso_oe(miso_oe), .o_cmd(cmd_out),
        .o_cmd_valid(cmd_valid), .o_err(err), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < N_CH; k++) ch_data[k*DATA_W +: DATA_W] = ch_model[k];
    end

    // Count command and error pulses.
    always @(negedge clk) begin
        if (cmd_valid) begin
            n_valid  <= n_valid + 1;
            last_cmd <= cmd_out;
        end
        if (err) n_err <= n_err + 1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: run did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] exp_word(input logic [7:0] c);
        if (c == 8'd0) return ID;
        else if (c <= 8'(N_CH)) return ch_model[c - 8'd1];
        else return '0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // action: 0 none, 1 change ch1 at data bit 20, 2 reset pulse at data bit 20
    task automatic spi_frame(input logic [7:0] c, input int cmd_bits, input int extra,
                             input int action, input string name);
        int base_v, base_e, exp_v, exp_e;
        logic [DATA_W-1:0] w;
        bit abort, got;
        base_v = n_valid;
        base_e = n_err;
        abort  = 1'b0;
        w      = exp_word(c);
        cs_n = 1'b0;
        tick(6);
        for (int i = 0; i < cmd_bits; i++) begin
            sclk = 1'b0; mosi = c[7-i]; tick(4);
            sclk = 1'b1; tick(4);
        end
        if (cmd_bits == 8) begin
            for (int j = 0; (j < DATA_W + extra) && !abort; j++) begin
                sclk = 1'b0;
                exp_q.push_back((j < DATA_W) ? w[DATA_W-1-j] : 1'b0);
                tick(4);
                sclk = 1'b1;
                tick(2);
                got = exp_q.pop_front();
                checks++;
                if (miso !== got) begin
                    failures++;
                    $display("FAIL %s_bit%0d: miso=%b want %b", name, j, miso, got);
                end
                checks++;
                if (miso_oe !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_oe%0d: oe=%b want 1", name, j, miso_oe);
                end
                tick(2);
                if (action == 1 && j == 20) ch_model[1] = 40'h55_5555_5555;
                if (action == 2 && j == 20) begin
                    rst_n = 1'b0;
                    tick(2);
                    checks++;
                    if ({miso, miso_oe, cmd_out, cmd_valid, err, busy} !== 13'd0) begin
                        failures++;
                        $display("FAIL %s_in_reset: outs=%h want 0", name,
                                 {miso, miso_oe, cmd_out, cmd_valid, err, busy});
                    end
                    rst_n  = 1'b1;
                    base_v = n_valid;
                    base_e = n_err;
                    for (int m = 0; m < 4; m++) begin
                        sclk = 1'b0; tick(4); sclk = 1'b1; tick(4);
                    end
                    checks++;
                    if ({busy, miso_oe, miso} !== 3'b000) begin
                        failures++;
                        $display("FAIL %s_no_resume: busy/oe/miso=%b want 000", name, {busy, miso_oe, miso});
                    end
                    abort = 1'b1;
                end
            end
        end
        sclk = 1'b0;
        tick(4);
        cs_n = 1'b1;
        tick(8);
        checks++;
        if ({busy, miso_oe, miso} !== 3'b000) begin
            failures++;
            $display("FAIL %s_end: busy/oe/miso=%b want 000", name, {busy, miso_oe, miso});
        end
        exp_v = (cmd_bits == 8 && action != 2) ? 1 : 0;
        exp_e = (exp_v == 1 && c > 8'(N_CH)) ? 1 : 0;
        checks++;
        if (n_valid - base_v != exp_v) begin
            failures++;
            $display("FAIL %s_valid_cnt: got %0d want %0d", name, n_valid - base_v, exp_v);
        end
        checks++;
        if (n_err - base_e != exp_e) begin
            failures++;
            $display("FAIL %s_err_cnt: got %0d want %0d", name, n_err - base_e, exp_e);
        end
        if (exp_v == 1) begin
            checks++;
            if (cmd_out !== c || last_cmd !== c) begin
                failures++;
                $display("FAIL %s_cmd: o_cmd=%h pulsed=%h want %h", name, cmd_out, last_cmd, c);
            end
        end
        if (action == 2) begin
            checks++;
            if (cmd_out !== 8'h00) begin
                failures++;
                $display("FAIL %s_cmd_cleared: o_cmd=%h want 00", name, cmd_out);
            end
        end
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if ({miso, miso_oe, cmd_out, cmd_valid, err, busy} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outs: outs=%h want 0", {miso, miso_oe, cmd_out, cmd_valid, err, busy});
        end
        rst_n = 1'b1;
        tick(8);
        checks++;
        if ({busy, miso_oe, cmd_out} !== 10'd0) begin
            failures++;
            $display("FAIL reset_release: busy/oe/cmd=%h want 0", {busy, miso_oe, cmd_out});
        end
    endtask

    task automatic test_read_channel();
        spi_frame(8'h01, 8, 0, 0, "ch0");
    endtask

    task automatic test_read_id();
        spi_frame(8'h00, 8, 0, 0, "id");
    endtask

    task automatic test_bad_addr();
        spi_frame(8'h05, 8, 0, 0, "bad_addr");
    endtask

    task automatic test_snapshot();
        ch_model[1] = 40'hAA_AAAA_AAAA;
        spi_frame(8'h02, 8, 0, 1, "snapshot");
    endtask

    task automatic test_abort();
        spi_frame(8'h03, 5, 0, 0, "abort");
        spi_frame(8'h03, 8, 0, 0, "after_abort");
    endtask

    task automatic test_reset_midframe();
        spi_frame(8'h01, 8, 0, 2, "mid_reset");
        spi_frame(8'h01, 8, 0, 0, "after_reset");
    endtask

    task automatic test_extra_clocks();
        spi_frame(8'h01, 8, 48, 0, "extra");
    endtask

    task automatic test_back_to_back();
        spi_frame(8'h03, 8, 0, 0, "b2b_a");
        spi_frame(8'h00, 8, 0, 0, "b2b_b");
        spi_frame(8'hFF, 8, 0, 0, "b2b_c");
    endtask

    initial begin
        ch_model[0] = 40'h12_3456_789A;
        ch_model[1] = 40'hAA_AAAA_AAAA;
        ch_model[2] = 40'h9C_3E71_0B5D;
        test_reset();
        test_read_channel();
        test_read_id();
        test_bad_addr();
        test_snapshot();
        test_abort();
        test_reset_midframe();
        test_extra_clocks();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
